// File: rtl/pwm_regs_shadowed.sv
// pwm_regs_shadowed: software-facing PWM register file with CTRL/STATUS,
// byte strobes, registered reads with error flag, and per-channel
// shadow/active double-buffering of period and duty.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_write_en/addr/data/strb       word write port with byte enables
//   o_write_err                     pulse the cycle after an out-of-range write
//   i_read_en/addr                  word read request
//   o_read_data/valid/err           registered read response (1-cycle latency)
//   i_period_end                    per-channel counter-wrap pulse from the core
//   o_prescale                      prescaler value
//   o_period/o_duty                 flattened active period/duty, channel n at [n*REG_WIDTH +: REG_WIDTH]
//   o_ch_enable                     global_en AND ch_en[n]
module pwm_regs_shadowed #(
  parameter int unsigned REG_WIDTH    = 16,
  parameter int unsigned NUM_CHANNELS = 4,
  localparam int unsigned ADDR_WIDTH  = $clog2(4 + 2 * NUM_CHANNELS)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_write_en,
  input  logic [ADDR_WIDTH-1:0]              i_write_addr,
  input  logic [31:0]                        i_write_data,
  input  logic [3:0]                         i_write_strb,
  output logic                               o_write_err,
  input  logic                               i_read_en,
  input  logic [ADDR_WIDTH-1:0]              i_read_addr,
  output logic [31:0]                        o_read_data,
  output logic                               o_read_valid,
  output logic                               o_read_err,
  input  logic [NUM_CHANNELS-1:0]            i_period_end,
  output logic [REG_WIDTH-1:0]               o_prescale,
  output logic [NUM_CHANNELS*REG_WIDTH-1:0]  o_period,
  output logic [NUM_CHANNELS*REG_WIDTH-1:0]  o_duty,
  output logic [NUM_CHANNELS-1:0]            o_ch_enable
);

  localparam int unsigned NUM_WORDS = 4 + 2 * NUM_CHANNELS;

  // Expand byte enables into a 32-bit bit mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

  // Byte-merge write data into a REG_WIDTH register; bits above REG_WIDTH drop.
  function automatic logic [REG_WIDTH-1:0] merge_reg(input logic [REG_WIDTH-1:0] old_val,
                                                     input logic [31:0] data,
                                                     input logic [3:0] strb);
    logic [31:0] mask;
    mask = strb_mask(strb);
    return REG_WIDTH'((32'(old_val) & ~mask) | (data & mask));
  endfunction

  // Byte-merge the ch_en field, which lives at CTRL[16 +: NUM_CHANNELS].
  function automatic logic [NUM_CHANNELS-1:0] merge_chen(input logic [NUM_CHANNELS-1:0] old_val,
                                                         input logic [31:0] data,
                                                         input logic [3:0] strb);
    logic [31:0] mask;
    mask = strb_mask(strb);
    return NUM_CHANNELS'((((32'(old_val) << 16) & ~mask) | (data & mask)) >> 16);
  endfunction

  // Duty above period saturates at period (100%).
  function automatic logic [REG_WIDTH-1:0] clamp(input logic [REG_WIDTH-1:0] d,
                                                 input logic [REG_WIDTH-1:0] p);
    return (d > p) ? p : d;
  endfunction

  logic                    r_global_en;
  logic                    r_mode;
  logic [NUM_CHANNELS-1:0] r_ch_en;
  logic [NUM_CHANNELS-1:0] r_ch_enable;
  logic [REG_WIDTH-1:0]    r_prescale;
  logic [REG_WIDTH-1:0]    r_shadow_period [NUM_CHANNELS];
  logic [REG_WIDTH-1:0]    r_shadow_duty   [NUM_CHANNELS];
  logic [REG_WIDTH-1:0]    r_act_period    [NUM_CHANNELS];
  logic [REG_WIDTH-1:0]    r_act_duty      [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] r_pending;
  logic [31:0]             r_read_data;
  logic                    r_read_valid;
  logic                    r_read_err;
  logic                    r_write_err;

  logic                    w_wr_oor;
  logic                    w_wr_ctrl;
  logic                    w_wr_prescale;
  logic                    w_force;
  logic                    w_global_en_n;
  logic                    w_mode_n;
  logic [NUM_CHANNELS-1:0] w_ch_en_n;
  logic [NUM_CHANNELS-1:0] w_wr_hit;
  logic [NUM_CHANNELS-1:0] w_commit;
  logic [REG_WIDTH-1:0]    w_shadow_period_n [NUM_CHANNELS];
  logic [REG_WIDTH-1:0]    w_shadow_duty_n   [NUM_CHANNELS];
  logic [31:0]             w_rd_data;
  logic                    w_rd_oor;

  // Write decode and next CTRL field values.
  always_comb begin
    w_wr_oor      = i_write_en && (32'(i_write_addr) >= NUM_WORDS);
    w_wr_ctrl     = i_write_en && (i_write_addr == ADDR_WIDTH'(0));
    w_wr_prescale = i_write_en && (i_write_addr == ADDR_WIDTH'(1));
    w_force       = w_wr_ctrl && i_write_strb[0] && i_write_data[2];
    w_global_en_n = r_global_en;
    w_mode_n      = r_mode;
    w_ch_en_n     = r_ch_en;
    if (w_wr_ctrl) begin
      if (i_write_strb[0]) begin
        w_global_en_n = i_write_data[0];
        w_mode_n      = i_write_data[1];
      end
      w_ch_en_n = merge_chen(r_ch_en, i_write_data, i_write_strb);
    end
  end

  // Per-channel write hit, post-write shadow values and commit condition.
  always_comb begin
    w_wr_hit = '0;
    w_commit = '0;
    for (int n = 0; n < int'(NUM_CHANNELS); n++) begin
      w_shadow_period_n[n] = r_shadow_period[n];
      w_shadow_duty_n[n]   = r_shadow_duty[n];
      w_wr_hit[n] = i_write_en && ((32'(i_write_addr) >> 1) == 32'(2 + n));
      if (w_wr_hit[n]) begin
        if (i_write_addr[0]) begin
          w_shadow_duty_n[n] = merge_reg(r_shadow_duty[n], i_write_data, i_write_strb);
        end else begin
          w_shadow_period_n[n] = merge_reg(r_shadow_period[n], i_write_data, i_write_strb);
        end
      end
      w_commit[n] = r_pending[n] && (i_period_end[n] || w_force);
    end
  end

  // Read mux over pre-edge state; out-of-range returns 0.
  always_comb begin
    w_rd_data = '0;
    w_rd_oor  = (32'(i_read_addr) >= NUM_WORDS);
    if (i_read_addr == ADDR_WIDTH'(0)) begin
      w_rd_data = (32'(r_ch_en) << 16) | {30'd0, r_mode, r_global_en};
    end else if (i_read_addr == ADDR_WIDTH'(1)) begin
      w_rd_data = 32'(r_prescale);
    end else if (i_read_addr == ADDR_WIDTH'(2)) begin
      w_rd_data = 32'(r_pending);
    end
    for (int n = 0; n < int'(NUM_CHANNELS); n++) begin
      if (32'(i_read_addr) == 32'(4 + 2 * n)) w_rd_data = 32'(r_shadow_period[n]);
      if (32'(i_read_addr) == 32'(5 + 2 * n)) w_rd_data = 32'(r_shadow_duty[n]);
    end
  end

  // CTRL, PRESCALE and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_global_en  <= 1'b0;
      r_mode       <= 1'b0;
      r_ch_en      <= '0;
      r_ch_enable  <= '0;
      r_prescale   <= '0;
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
      r_read_err   <= 1'b0;
      r_write_err  <= 1'b0;
    end else begin
      r_global_en  <= w_global_en_n;
      r_mode       <= w_mode_n;
      r_ch_en      <= w_ch_en_n;
      r_ch_enable  <= {NUM_CHANNELS{w_global_en_n}} & w_ch_en_n;
      if (w_wr_prescale) r_prescale <= merge_reg(r_prescale, i_write_data, i_write_strb);
      r_read_valid <= i_read_en;
      r_read_err   <= i_read_en && w_rd_oor;
      if (i_read_en) r_read_data <= w_rd_data;
      r_write_err  <= w_wr_oor;
    end
  end

  // Shadow/active channel registers. A write in the same cycle as a commit
  // lands in shadow after the commit has taken the old shadow, so pending stays.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      for (int n = 0; n < int'(NUM_CHANNELS); n++) begin
        r_shadow_period[n] <= '0;
        r_shadow_duty[n]   <= '0;
        r_act_period[n]    <= '0;
        r_act_duty[n]      <= '0;
      end
    end else begin
      for (int n = 0; n < int'(NUM_CHANNELS); n++) begin
        r_shadow_period[n] <= w_shadow_period_n[n];
        r_shadow_duty[n]   <= w_shadow_duty_n[n];
        if (w_commit[n]) begin
          r_act_period[n] <= r_shadow_period[n];
          r_act_duty[n]   <= clamp(r_shadow_duty[n], r_shadow_period[n]);
          r_pending[n]    <= 1'b0;
        end
        if (w_wr_hit[n]) begin
          if (r_mode) begin
            r_act_period[n] <= w_shadow_period_n[n];
            r_act_duty[n]   <= clamp(w_shadow_duty_n[n], w_shadow_period_n[n]);
          end else begin
            r_pending[n] <= 1'b1;
          end
        end
      end
    end
  end

  // Flatten active values onto the core-facing buses.
  always_comb begin
    o_period = '0;
    o_duty   = '0;
    for (int n = 0; n < int'(NUM_CHANNELS); n++) begin
      o_period[n*REG_WIDTH +: REG_WIDTH] = r_act_period[n];
      o_duty[n*REG_WIDTH +: REG_WIDTH]   = r_act_duty[n];
    end
  end

  assign o_prescale   = r_prescale;
  assign o_ch_enable  = r_ch_enable;
  assign o_read_data  = r_read_data;
  assign o_read_valid = r_read_valid;
  assign o_read_err   = r_read_err;
  assign o_write_err  = r_write_err;

endmodule

// File: doc/pwm_regs_shadowed.md
Name: pwm_regs_shadowed

Overview:
Software-facing PWM register file, successor to the flat register bank. Sits between the AXI4-Lite slave decoder and the multi-channel PWM core. Adds a control/status register, byte strobes, registered reads with error reporting, and per-channel shadow/active double-buffering. Channel period/duty changes therefore take effect glitch-free at each channel's period boundary.

Parameters:
REG_WIDTH, 16, width of prescale/period/duty registers (1..32)
NUM_CHANNELS, 4, number of PWM channels (1..16)
ADDR_WIDTH, localparam $clog2(4+2*NUM_CHANNELS), word-address width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
write_en  input  1  write request, one word per cycle
write_addr  input  ADDR_WIDTH  word address
write_data  input  32  write data
write_strb  input  4  byte enables
write_err  output  1  1-cycle pulse, cycle after an out-of-range write
read_en  input  1  read request
read_addr  input  ADDR_WIDTH  word address
read_data  output  32  read data, registered
read_valid  output  1  1-cycle pulse, cycle after read_en
read_err  output  1  qualifies read_valid: out-of-range address
period_end  input  NUM_CHANNELS  per-channel 1-cycle pulse from core at counter wrap
prescale  output  REG_WIDTH  prescaler value to core
period  output  REG_WIDTH x NUM_CHANNELS  active period per channel
duty  output  REG_WIDTH x NUM_CHANNELS  active (clamped) duty per channel
ch_enable  output  NUM_CHANNELS  CTRL.global_en AND CTRL.ch_en[n]

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous, active-low. While low, every register and output is 0, including read_valid, write_err and pending.
- Address map (word):
  - 0 CTRL: bit0 global_en; bit1 mode (0 = sync, 1 = immediate); bit2 force_update (write-one, self-clearing, reads 0); bits[16+NUM_CHANNELS-1:16] ch_en.
  - 1 PRESCALE.
  - 2 STATUS: bits[NUM_CHANNELS-1:0] pending. Read-only; writes are silently ignored.
  - 3 reserved: reads 0, writes ignored, no error.
  - 4+2n PERIOD shadow of channel n; 5+2n DUTY shadow of channel n.
  - Address >= 4+2*NUM_CHANNELS is out-of-range.
- Writes:
  - Take effect at the same clock edge as write_en.
  - write_strb[b] updates byte b only. Data bits at or above REG_WIDTH are discarded.
  - CTRL and PRESCALE apply directly to outputs, with no shadowing.
  - An out-of-range write changes nothing and pulses write_err on the next cycle.
- Channel writes, mode 0 (sync):
  - The write updates the shadow register and sets pending[n].
  - Commit of channel n occurs at an edge where pending[n] && (period_end[n] || force_update write). At commit: active period <= shadow period; active duty <= min(shadow duty, shadow period); pending[n] cleared.
  - Commit uses pre-edge shadow values.
  - A channel write coinciding with its commit: commit takes the old shadow value, the new value lands in shadow, and pending[n] stays 1.
- Channel writes, mode 1 (immediate):
  - The write updates shadow and active at the same edge, with the same clamp applied. pending[n] is not set.
  - Switching mode 0 -> 1 does not flush existing pending channels. They commit on their next period_end or force_update.
- Reads:
  - Latency is 1 cycle: read_data, read_valid and read_err are registered.
  - PERIOD/DUTY reads return the shadow value. Read and write to the same address in the same cycle returns the pre-write value.
  - Out-of-range read: read_data = 0, read_valid = 1, read_err = 1.
  - Back-to-back reads are supported, one per cycle.
- Clamp: duty > period yields active duty = period (100%). A period of 0 is passed through; the core defines its behaviour.

Test Plan:
- Reset then read addr 0..12 (NUM_CHANNELS=4) -> all data 0; addr 12 gives read_err=1; each read_valid appears exactly 1 cycle after read_en.
- Mode 0: write PERIOD0=1000, DUTY0=250 -> period[0]/duty[0] stay 0 and STATUS=0x1 until a period_end[0] pulse; on the next cycle they read 1000/250 and STATUS=0x0.
- Write DUTY1=0x1234 in the same cycle as period_end[1] with pending[1]=1 (old shadow duty 0x0100, period 0x0200) -> duty[1]=0x0100, shadow=0x1234, pending[1] remains 1.
- Mode 1: write PERIOD2=100, then DUTY2=150 -> period[2]=100 and duty[2]=100 (clamped) on the cycle after each write; STATUS bit2=0.
- Write PRESCALE=0xABCD with strb=0001 from 0 -> prescale=0x00CD; write CTRL=0x0003_0001 -> ch_enable=0011. Then write CTRL with force_update and pending=0101 -> both channels commit at that edge and CTRL readback bit2=0.
- Write to addr 13 -> write_err pulse; no register changes. Assert rst_n low mid-sequence -> all outputs 0 immediately, with no clock edge required.
